// File: rtl/parity_chk_pkg.sv
// rtl/parity_chk_pkg.sv - shared types and field positions for the nibble parity checker
package parity_chk_pkg;

    // Frame FSM: collect words, then hold the frame result until it is taken
    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } chk_state_e;

    // Layout of the {parity, nibble} word produced by the generator
    localparam int DP_PAR_BIT  = 4;
    localparam int DP_DATA_MSB = 3;
    localparam int NIBBLE_W    = 4;

endpackage

// File: rtl/nibble_parity_check.sv
// rtl/nibble_parity_check.sv - single-word parity re-check of a {parity, nibble} word
module nibble_parity_check
    import parity_chk_pkg::*;
(
    input  logic [DP_PAR_BIT:0]  dp_i,
    input  logic [NIBBLE_W-1:0]  en_i,
    output logic                 mismatch_o,
    output logic                 exp_o
);

    // Expected parity covers only the data bits the generator had enabled
    assign exp_o      = ^(dp_i[DP_DATA_MSB:0] & en_i);
    assign mismatch_o = exp_o ^ dp_i[DP_PAR_BIT];

endmodule

// File: rtl/nibble_parity_checker.sv
// rtl/nibble_parity_checker.sv - frame accumulator of parity checks with handshaked result
module nibble_parity_checker
    import parity_chk_pkg::*;
#(
    parameter  int FRAME_NIBBLES = 8,
    localparam int CNT_W         = $clog2(FRAME_NIBBLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DP_PAR_BIT:0]  in_dp,
    input  logic [NIBBLE_W-1:0]  in_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_frame_par,
    output logic [CNT_W-1:0]     out_err_cnt,
    output logic                 out_err
);

    chk_state_e         state_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               par_acc_q;
    logic [CNT_W-1:0]   err_acc_q;
    logic               out_valid_q;
    logic               out_frame_par_q;
    logic [CNT_W-1:0]   out_err_cnt_q;
    logic               out_err_q;

    logic               word_mismatch;
    logic               word_exp_unused;
    logic               accept;
    logic               last_word;
    logic               par_acc_d;
    logic [CNT_W-1:0]   err_acc_d;
    logic [CNT_W-1:0]   word_cnt_d;

    nibble_parity_check u_check (
        .dp_i       (in_dp),
        .en_i       (in_en),
        .mismatch_o (word_mismatch),
        .exp_o      (word_exp_unused)
    );

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid & in_ready;
    assign last_word = (word_cnt_q == CNT_W'(FRAME_NIBBLES - 1));

    // Accumulator values including the word presented this cycle
    always_comb begin
        par_acc_d  = par_acc_q ^ in_dp[DP_PAR_BIT];
        err_acc_d  = err_acc_q + {{(CNT_W-1){1'b0}}, word_mismatch};
        word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Frame FSM: accumulate words, latch the result on the last word, wait for it to be taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ACCUM;
            word_cnt_q      <= '0;
            par_acc_q       <= 1'b0;
            err_acc_q       <= '0;
            out_valid_q     <= 1'b0;
            out_frame_par_q <= 1'b0;
            out_err_cnt_q   <= '0;
            out_err_q       <= 1'b0;
        end else if (clr) begin
            // Abort drops the partial frame and any pending result, but keeps the old data values
            state_q     <= ACCUM;
            word_cnt_q  <= '0;
            par_acc_q   <= 1'b0;
            err_acc_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (last_word) begin
                            out_frame_par_q <= par_acc_d;
                            out_err_cnt_q   <= err_acc_d;
                            out_err_q       <= (err_acc_d != '0);
                            out_valid_q     <= 1'b1;
                            state_q         <= REPORT;
                        end
                        word_cnt_q <= word_cnt_d;
                        par_acc_q  <= par_acc_d;
                        err_acc_q  <= err_acc_d;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        word_cnt_q  <= '0;
                        par_acc_q   <= 1'b0;
                        err_acc_q   <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_frame_par = out_frame_par_q;
    assign out_err_cnt   = out_err_cnt_q;
    assign out_err       = out_err_q;

endmodule

// File: tb/tb_nibble_parity_checker.sv
// tb/tb_nibble_parity_checker.sv - self-checking bench for nibble_parity_checker
module tb_nibble_parity_checker;

    localparam int FN = 8;
    localparam int CW = $clog2(FN + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_dp;
    logic [3:0]    in_en;
    logic          out_valid;
    logic          out_ready;
    logic          out_frame_par;
    logic [CW-1:0] out_err_cnt;
    logic          out_err;

    int checks = 0;
    int errors = 0;

    logic [4:0] w_dp [FN];
    logic [3:0] w_en [FN];

    typedef struct {
        logic [3:0] d;
        logic [3:0] en;
        logic [7:0] pbits;
        logic       exp_par;
        int         exp_err;
    } frame_vec_t;

    frame_vec_t vecs [5];

    always #5 clk = ~clk;

    nibble_parity_checker #(.FRAME_NIBBLES(FN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dp         (in_dp),
        .in_en         (in_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_frame_par (out_frame_par),
        .out_err_cnt   (out_err_cnt),
        .out_err       (out_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: frame parity is the parity of the count of set parity bits; a word is in error
    // when the number of enabled set data bits is odd and the parity bit is 0, or vice versa
    function automatic void model(output logic p, output int e);
        int ones;
        ones = 0;
        e    = 0;
        for (int i = 0; i < FN; i++) begin
            ones += int'(w_dp[i][4]);
            if (($countones(w_dp[i][3:0] & w_en[i]) % 2) != int'(w_dp[i][4]))
                e++;
        end
        p = logic'(ones % 2);
    endfunction

    // Present one word from a negedge until it is accepted, return at the next negedge
    task automatic send_word(input logic [4:0] dp, input logic [3:0] en, input logic with_clr);
        int n;
        in_valid = 1'b1;
        in_dp    = dp;
        in_en    = en;
        clr      = with_clr;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        in_dp    = 5'($urandom);
        in_en    = 4'($urandom);
    endtask

    // Send w_dp/w_en as a full frame, check latency/result, backpressure, then complete handshake
    task automatic run_frame(input string tag, input logic exp_par, input int exp_err,
                             input int gap_max, input int bp);
        for (int i = 0; i < FN; i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            send_word(w_dp[i], w_en[i], 1'b0);
            if (i < FN - 1) chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        chk({tag, "_valid"},   32'(out_valid),     32'd1);
        chk({tag, "_par"},     32'(out_frame_par), 32'(exp_par));
        chk({tag, "_err_cnt"}, 32'(out_err_cnt),   32'(exp_err));
        chk({tag, "_err"},     32'(out_err),       32'(exp_err != 0));
        out_ready = 1'b0;
        in_valid  = (bp > 0);
        in_dp     = 5'b0_0001;
        in_en     = 4'hF;
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk({tag, "_bp_ready"},   32'(in_ready),    32'd0);
            chk({tag, "_bp_valid"},   32'(out_valid),   32'd1);
            chk({tag, "_bp_err_cnt"}, 32'(out_err_cnt), 32'(exp_err));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_ready"}, 32'(in_ready),      32'd1);
        chk({tag, "_post_valid"}, 32'(out_valid),     32'd0);
        chk({tag, "_held_par"},   32'(out_frame_par), 32'(exp_par));
    endtask

    task automatic load_vec(input frame_vec_t v);
        for (int i = 0; i < FN; i++) begin
            w_dp[i] = {v.pbits[i], v.d};
            w_en[i] = v.en;
        end
    endtask

    initial begin
        vecs[0] = '{d: 4'hF, en: 4'hF,    pbits: 8'b0000_0000, exp_par: 1'b0, exp_err: 0};
        vecs[1] = '{d: 4'h1, en: 4'h1,    pbits: 8'b1110_1101, exp_par: 1'b0, exp_err: 2};
        vecs[2] = '{d: 4'hF, en: 4'b0001, pbits: 8'b1111_1111, exp_par: 1'b0, exp_err: 0};
        vecs[3] = '{d: 4'hF, en: 4'b0001, pbits: 8'b0000_0000, exp_par: 1'b0, exp_err: 8};
        vecs[4] = '{d: 4'hA, en: 4'hC,    pbits: 8'b0000_0001, exp_par: 1'b1, exp_err: 7};

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_dp     = '0;
        in_en     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),      32'd1);
        chk("rst_out_valid", 32'(out_valid),     32'd0);
        chk("rst_par",       32'(out_frame_par), 32'd0);
        chk("rst_err_cnt",   32'(out_err_cnt),   32'd0);
        chk("rst_err",       32'(out_err),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            load_vec(vecs[v]);
            run_frame($sformatf("vec%0d", v), vecs[v].exp_par, vecs[v].exp_err, 0,
                      (v == 1) ? 5 : 0);
        end

        // Reset after 3 words of a frame: partial frame lost, outputs cleared
        load_vec(vecs[1]);
        for (int i = 0; i < 3; i++) send_word(w_dp[i], w_en[i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  32'(in_ready),      32'd1);
        chk("midrst_out_valid", 32'(out_valid),     32'd0);
        chk("midrst_par",       32'(out_frame_par), 32'd0);
        chk("midrst_err_cnt",   32'(out_err_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready",  32'(in_ready),    32'd1);
        chk("rel_out_valid", 32'(out_valid),   32'd0);
        chk("rel_err",       32'(out_err),     32'd0);
        load_vec(vecs[4]);
        run_frame("after_rst", vecs[4].exp_par, vecs[4].exp_err, 0, 0);

        // clr with a word on the 4th beat: that word and the 3 before are discarded
        for (int i = 0; i < 3; i++) send_word(5'b0_0001, 4'h1, 1'b0);
        send_word(5'b1_0000, 4'hF, 1'b1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < FN; i++) begin
            w_dp[i] = 5'b0_0011;
            w_en[i] = 4'h3;
        end
        run_frame("clr", 1'b0, 0, 0, 0);

        // Randomized frames against the reference model
        for (int f = 0; f < 20; f++) begin
            logic p;
            int   e;
            for (int i = 0; i < FN; i++) begin
                w_dp[i] = 5'($urandom);
                w_en[i] = 4'($urandom);
            end
            model(p, e);
            run_frame($sformatf("rand%0d", f), p, e, 2, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
